// File: rtl/uart_msg_arbiter.sv
// Shares one UART byte transmitter between alarm, status and measurement frame sources.
// Grants whole frames, paces bytes on tx_done, enforces an inter-frame gap and a stall timeout.
module uart_msg_arbiter #(
  parameter int unsigned GAP_CYC = 200_000,
  parameter int unsigned TIMEOUT = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  i_req,
  input  logic [23:0] i_req_data,
  input  logic [2:0]  i_req_last,
  output logic [2:0]  o_req_ack,
  output logic        o_send_en,
  output logic [7:0]  o_data_byte,
  input  logic        i_tx_done,
  output logic [2:0]  o_gnt,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_abort
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  // A zero gap still spends one cycle in GAP before returning to IDLE.
  localparam logic [23:0] LP_GAP_LAST = (GAP_CYC == 32'd0) ? 24'd0 : 24'(GAP_CYC - 32'd1);
  localparam logic [23:0] LP_TMO_LAST = 24'(TIMEOUT - 32'd1);

  state_t      r_state;
  logic [1:0]  r_own;
  logic        r_rr_sel2;
  logic        r_last;
  logic [23:0] r_cnt;

  logic        w_own_req;
  logic        w_own_last;
  logic [7:0]  w_own_data;

  // Select the current owner's request, byte and last flag
  always_comb begin
    w_own_req  = 1'b0;
    w_own_last = 1'b0;
    w_own_data = 8'd0;
    case (r_own)
      2'd0: begin
        w_own_req  = i_req[0];
        w_own_last = i_req_last[0];
        w_own_data = i_req_data[7:0];
      end
      2'd1: begin
        w_own_req  = i_req[1];
        w_own_last = i_req_last[1];
        w_own_data = i_req_data[15:8];
      end
      2'd2: begin
        w_own_req  = i_req[2];
        w_own_last = i_req_last[2];
        w_own_data = i_req_data[23:16];
      end
      default: begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_own_data = 8'd0;
      end
    endcase
  end

  // Arbitration, byte pacing, timeout and gap sequencing with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_own        <= 2'd0;
      r_rr_sel2    <= 1'b0;
      r_last       <= 1'b0;
      r_cnt        <= 24'd0;
      o_req_ack    <= 3'b000;
      o_send_en    <= 1'b0;
      o_data_byte  <= 8'd0;
      o_gnt        <= 3'b000;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_abort      <= 1'b0;
    end else begin
      o_send_en    <= 1'b0;
      o_req_ack    <= 3'b000;
      o_frame_done <= 1'b0;
      o_abort      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req[0]) begin
            r_own   <= 2'd0;
            o_gnt   <= 3'b001;
            o_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end else if (i_req[1] && (!i_req[2] || !r_rr_sel2)) begin
            r_own     <= 2'd1;
            o_gnt     <= 3'b010;
            r_rr_sel2 <= 1'b1;
            o_busy    <= 1'b1;
            r_state   <= ST_LOAD;
          end else if (i_req[2]) begin
            r_own     <= 2'd2;
            o_gnt     <= 3'b100;
            r_rr_sel2 <= 1'b0;
            o_busy    <= 1'b1;
            r_state   <= ST_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (w_own_req) begin
            o_data_byte <= w_own_data;
            r_last      <= w_own_last;
            o_send_en   <= 1'b1;
            o_req_ack   <= 3'b001 << r_own;
            r_cnt       <= 24'd0;
            r_state     <= ST_WAIT_DONE;
          end else begin
            o_abort <= 1'b1;
            o_gnt   <= 3'b000;
            r_cnt   <= 24'd0;
            r_state <= ST_GAP;
          end
        end
        ST_WAIT_DONE: begin
          // tx_done during the strobe cycle belongs to the previous byte
          if (i_tx_done && !o_send_en) begin
            if (r_last) begin
              o_frame_done <= 1'b1;
              o_gnt        <= 3'b000;
              r_cnt        <= 24'd0;
              r_state      <= ST_GAP;
            end else begin
              r_state <= ST_LOAD;
            end
          end else if (r_cnt >= LP_TMO_LAST) begin
            o_abort <= 1'b1;
            o_gnt   <= 3'b000;
            r_cnt   <= 24'd0;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt >= LP_GAP_LAST) begin
            o_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        default: begin
          o_gnt   <= 3'b000;
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Self-checking bench for uart_msg_arbiter: requesters and UART are modelled as byte queues
// and delays; a transaction-level model predicts grants, strobes, pulses and their timing.
module tb_uart_msg_arbiter;
  localparam int GAP = 4;
  localparam int TMO = 20;

  logic        clk;
  logic        rst_n;
  logic [2:0]  i_req;
  logic [23:0] i_req_data;
  logic [2:0]  i_req_last;
  logic [2:0]  o_req_ack;
  logic        o_send_en;
  logic [7:0]  o_data_byte;
  logic        i_tx_done;
  logic [2:0]  o_gnt;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_abort;

  uart_msg_arbiter #(.GAP_CYC(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_req_data(i_req_data),
    .i_req_last(i_req_last), .o_req_ack(o_req_ack), .o_send_en(o_send_en),
    .o_data_byte(o_data_byte), .i_tx_done(i_tx_done), .o_gnt(o_gnt),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_abort(o_abort)
  );

  int n_chk, n_fail, cyc;
  logic [7:0] fbytes [3][32];
  bit  flast [3][32];
  int  fpos [3];
  int  flen [3];
  bit  req_on [3];
  bit  drop_after_ack [3];
  int  m_owner, m_rr, last_end, m_req_since;
  int  send_due, txd_due, fd_due, abort_due;
  bit  cur_last;
  int  uart_mode, uart_delay, silent_cnt;
  int  n_send [3];
  int  n_fd, n_abort;
  int  hist [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit pending(input int r);
    return req_on[r] && (fpos[r] < flen[r]);
  endfunction

  function automatic int winner(input logic [2:0] r);
    if (r[0]) return 0;
    if (r[1] && r[2]) return m_rr;
    if (r[1]) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rr = 1; last_end = -100; m_req_since = -100;
    send_due = -1; txd_due = -1; fd_due = -1; abort_due = -1;
    silent_cnt = 0;
    for (int r = 0; r < 3; r++) begin
      fpos[r] = 0; flen[r] = 0; req_on[r] = 1'b0; drop_after_ack[r] = 1'b0;
    end
  endtask

  task automatic clear_frames();
    for (int r = 0; r < 3; r++) begin
      fpos[r] = 0; flen[r] = 0;
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] b, input bit last);
    fbytes[r][flen[r]] = b;
    flast[r][flen[r]] = last;
    flen[r]++;
    req_on[r] = 1'b1;
  endtask

  task automatic drive();
    logic [2:0]  nr;
    logic [23:0] nd;
    logic [2:0]  nl;
    nr = 3'b000; nd = 24'd0; nl = 3'b000;
    for (int r = 0; r < 3; r++) begin
      if (pending(r)) begin
        nr[r] = 1'b1;
        nd[8*r +: 8] = fbytes[r][fpos[r]];
        nl[r] = flast[r][fpos[r]];
      end
    end
    if (m_owner < 0 && i_req == 3'b000 && nr != 3'b000) m_req_since = cyc;
    i_req = nr; i_req_data = nd; i_req_last = nl;
  endtask

  task automatic step();
    int due, w;
    logic [2:0] eg, ea;
    @(negedge clk);
    cyc++;
    chk("frame_done", o_frame_done, (cyc == fd_due) ? 1 : 0);
    chk("abort", o_abort, (cyc == abort_due) ? 1 : 0);
    if (cyc == fd_due || cyc == abort_due) begin
      if (cyc == fd_due) n_fd++;
      else begin
        n_abort++;
        if (m_owner >= 0) flen[m_owner] = fpos[m_owner];
      end
      m_owner = -1;
      last_end = cyc;
    end
    if (m_owner < 0) begin
      due = (last_end + GAP + 1 > m_req_since + 1) ? last_end + GAP + 1 : m_req_since + 1;
      eg = 3'b000;
      w = 0;
      if (i_req != 3'b000 && cyc >= due) begin
        w = winner(i_req);
        eg = 3'b001 << w;
      end
      chk("gnt_idle", o_gnt, eg);
      if (eg != 3'b000) begin
        m_owner = w;
        if (w == 1) m_rr = 2;
        else if (w == 2) m_rr = 1;
        hist.push_back(w);
        send_due = cyc + 1;
      end
    end else begin
      chk("gnt_hold", o_gnt, 3'b001 << m_owner);
    end
    chk("busy", o_busy, (m_owner >= 0 || cyc < last_end + GAP) ? 1 : 0);
    ea = (cyc == send_due && m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    chk("send_en", o_send_en, (cyc == send_due) ? 1 : 0);
    chk("req_ack", o_req_ack, ea);
    if (cyc == send_due && m_owner >= 0) begin
      chk("data_byte", o_data_byte, fbytes[m_owner][fpos[m_owner]]);
      cur_last = flast[m_owner][fpos[m_owner]];
      fpos[m_owner]++;
      n_send[m_owner]++;
      if (drop_after_ack[m_owner]) req_on[m_owner] = 1'b0;
      if (silent_cnt > 0) begin
        silent_cnt--;
        abort_due = cyc + TMO;
      end else begin
        txd_due = cyc + ((uart_mode == 2) ? int'($urandom_range(19, 1)) : uart_delay);
      end
    end
    drive();
    i_tx_done = (cyc == txd_due);
    if (cyc == txd_due && m_owner >= 0) begin
      if (cur_last) fd_due = cyc + 1;
      else if (i_req[m_owner]) send_due = cyc + 2;
      else abort_due = cyc + 2;
    end
  endtask

  task automatic run_idle(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      step();
      done = !pending(0) && !pending(1) && !pending(2) && m_owner < 0 && cyc >= last_end + GAP;
    end
    chk({tag, "_budget"}, {31'd0, done}, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, o_gnt, 0);
    chk({tag, "_send_en"}, o_send_en, 0);
    chk({tag, "_req_ack"}, o_req_ack, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_frame_done"}, o_frame_done, 0);
    chk({tag, "_abort"}, o_abort, 0);
    chk({tag, "_data_byte"}, o_data_byte, 0);
  endtask

  initial begin
    int s0, a0, f0, tot;
    n_chk = 0; n_fail = 0; cyc = 0;
    n_fd = 0; n_abort = 0;
    for (int r = 0; r < 3; r++) n_send[r] = 0;
    rst_n = 1'b0; i_req = 3'b000; i_req_data = 24'd0; i_req_last = 3'b000; i_tx_done = 1'b0;
    cur_last = 1'b0;
    model_reset();
    uart_mode = 1; uart_delay = 5;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Three-byte status frame, UART answers 5 cycles after each strobe
    add_byte(1, 8'h43, 1'b0); add_byte(1, 8'h4C, 1'b0); add_byte(1, 8'h53, 1'b1);
    drive();
    run_idle("t1", 200);
    chk("t1_sends", n_send[1], 3);
    chk("t1_frame_done", n_fd, 1);

    // Alarm and requester 1 together: alarm first, requester 1 after the gap
    clear_frames(); hist.delete();
    add_byte(0, 8'hA1, 1'b1); add_byte(1, 8'hB2, 1'b1);
    drive();
    run_idle("t2", 200);
    chk("t2_grants", hist.size(), 2);
    if (hist.size() == 2) begin
      chk("t2_first", hist[0], 0);
      chk("t2_second", hist[1], 1);
    end

    // Requesters 1 and 2 continuously requesting one-byte frames alternate
    clear_frames(); hist.delete();
    for (int k = 0; k < 3; k++) begin
      add_byte(1, 8'h30 + 8'(k), 1'b1);
      add_byte(2, 8'h60 + 8'(k), 1'b1);
    end
    drive();
    run_idle("t3", 600);
    chk("t3_grants", hist.size(), 6);
    if (hist.size() == 6) begin
      chk("t3_first", hist[0], 2);
      for (int k = 1; k < 6; k++) chk("t3_alternate", (hist[k] != hist[k-1]) ? 1 : 0, 1);
    end

    // Silent UART on the first byte: timeout abort, then the other requester after the gap
    clear_frames(); a0 = n_abort; f0 = n_fd;
    silent_cnt = 1;
    add_byte(1, 8'h10, 1'b0); add_byte(1, 8'h11, 1'b1); add_byte(2, 8'h20, 1'b1);
    drive();
    run_idle("t4", 300);
    chk("t4_aborts", n_abort - a0, 1);
    chk("t4_frames", n_fd - f0, 1);

    // Requester 2 withdraws after its first ack: no further strobe, abort
    clear_frames(); a0 = n_abort; s0 = n_send[2];
    drop_after_ack[2] = 1'b1;
    add_byte(2, 8'h71, 1'b0); add_byte(2, 8'h72, 1'b0); add_byte(2, 8'h73, 1'b1);
    drive();
    run_idle("t5", 200);
    drop_after_ack[2] = 1'b0;
    chk("t5_aborts", n_abort - a0, 1);
    chk("t5_sends", n_send[2] - s0, 1);

    // Reset while waiting for tx_done, then a fresh round-robin grant
    clear_frames();
    add_byte(1, 8'h81, 1'b0); add_byte(1, 8'h82, 1'b1);
    drive();
    s0 = n_send[1];
    for (int k = 0; k < 20 && n_send[1] == s0; k++) step();
    chk("t6_sent", n_send[1] - s0, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_reset");
    model_reset();
    drive();
    i_tx_done = 1'b0;
    step(); step();
    rst_n = 1'b1;
    hist.delete();
    add_byte(2, 8'h92, 1'b1); add_byte(1, 8'h91, 1'b1);
    drive();
    run_idle("t6", 200);
    chk("t6_grants", hist.size(), 2);
    if (hist.size() == 2) chk("t6_first", hist[0], 1);

    // Random frame mixes with random UART latency
    uart_mode = 2;
    for (int round = 0; round < 5; round++) begin
      clear_frames();
      tot = 0;
      s0 = n_send[0] + n_send[1] + n_send[2];
      for (int r = 0; r < 3; r++) begin
        int nf;
        nf = $urandom_range(3, 0);
        for (int f = 0; f < nf; f++) begin
          int len;
          len = $urandom_range(3, 1);
          for (int b = 0; b < len; b++) add_byte(r, 8'($urandom), (b == len - 1));
          tot += len;
        end
      end
      drive();
      run_idle("rand", 3000);
      chk("rand_bytes", n_send[0] + n_send[1] + n_send[2] - s0, tot);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
